// File: rtl/fir_tap_scheduler.sv
// Sequencer for the time-multiplexed symmetric FIR: FIFO pop, delay-line shift, tap-group walk, MAC drain, result handshake.
// Optional FIR_SCHED_STALL_CNT_EN adds a saturating 16-bit output-backpressure counter (stall_cnt).
module fir_tap_scheduler #(
    parameter int N_GROUPS = 3,
    parameter int GRP_W    = 2,
    parameter int MAC_LAT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             shift_en,
    output logic [GRP_W-1:0] group,
    output logic             grp_valid,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef FIR_SCHED_STALL_CNT_EN
   ,output logic [15:0]      stall_cnt
`endif
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COMP  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t          state;
    logic [DW-1:0]   drain_cnt;

    // Pop is gated by reset so a word is never consumed while the scheduler is held.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (reset && !fifo_empty) begin
            if (state == IDLE)
                fifo_rd_en = 1'b1;
            else if (state == OUT && out_ready)
                fifo_rd_en = 1'b1;
        end
    end

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            group     <= '1;
            drain_cnt <= '0;
            shift_en  <= 1'b0;
            grp_valid <= 1'b0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            last      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            shift_en  <= 1'b0;
            grp_valid <= 1'b0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            last      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= LOAD;
                        shift_en <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= COMP;
                    group     <= '0;
                    grp_valid <= 1'b1;
                    acc_clr   <= 1'b1;
                    acc_en    <= 1'b1;
                    last      <= (N_GROUPS == 1);
                end
                COMP: begin
                    // The registered last flag marks the final group of this sample.
                    if (last) begin
                        group <= '1;
                        if (MAC_LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
                        end else begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        group     <= group + 1'b1;
                        grp_valid <= 1'b1;
                        acc_en    <= 1'b1;
                        last      <= (group == GRP_W'(N_GROUPS - 2));
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!fifo_empty) begin
                            state    <= LOAD;
                            shift_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    group <= '1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIR_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler: default instance plus an N_GROUPS=1, MAC_LAT=0 instance.
module tb_fir_tap_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty, out_ready;
    logic       fifo_rd_en, shift_en, grp_valid, acc_clr, acc_en, last, out_valid, busy;
    logic [1:0] group;
    logic       b_fifo_empty, b_out_ready;
    logic       b_fifo_rd_en, b_shift_en, b_grp_valid, b_acc_clr, b_acc_en, b_last, b_out_valid, b_busy;
    logic [1:0] b_group;
`ifdef FIR_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt, b_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_tap_scheduler #(.N_GROUPS(3), .GRP_W(2), .MAC_LAT(2)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .shift_en(shift_en), .group(group), .grp_valid(grp_valid), .acc_clr(acc_clr),
        .acc_en(acc_en), .last(last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
`ifdef FIR_SCHED_STALL_CNT_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    fir_tap_scheduler #(.N_GROUPS(1), .GRP_W(2), .MAC_LAT(0)) dut_b (
        .clk(clk), .reset(reset), .fifo_empty(b_fifo_empty), .fifo_rd_en(b_fifo_rd_en),
        .shift_en(b_shift_en), .group(b_group), .grp_valid(b_grp_valid), .acc_clr(b_acc_clr),
        .acc_en(b_acc_en), .last(b_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .busy(b_busy)
`ifdef FIR_SCHED_STALL_CNT_EN
       ,.stall_cnt(b_stall_cnt)
`endif
    );

    // {rd_en, shift_en, grp_valid, acc_clr, acc_en, last, out_valid, busy, group[1:0]}
    function automatic logic [9:0] vec_a();
        return {fifo_rd_en, shift_en, grp_valid, acc_clr, acc_en, last, out_valid, busy, group};
    endfunction

    function automatic logic [9:0] vec_b();
        return {b_fifo_rd_en, b_shift_en, b_grp_valid, b_acc_clr, b_acc_en, b_last,
                b_out_valid, b_busy, b_group};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic fe, input logic rdy);
        @(negedge clk);
        fifo_empty = fe;
        out_ready  = rdy;
        #1;
    endtask

    task automatic step_b(input logic fe, input logic rdy);
        @(negedge clk);
        b_fifo_empty = fe;
        b_out_ready  = rdy;
        #1;
    endtask

    logic [9:0] single_tbl [0:8];
    logic [9:0] b_tbl [0:4];

    initial begin
        single_tbl[0] = 10'b1000000011;
        single_tbl[1] = 10'b0100000111;
        single_tbl[2] = 10'b0011100100;
        single_tbl[3] = 10'b0010100101;
        single_tbl[4] = 10'b0010110110;
        single_tbl[5] = 10'b0000000111;
        single_tbl[6] = 10'b0000000111;
        single_tbl[7] = 10'b0000001111;
        single_tbl[8] = 10'b0000000011;
        b_tbl[0] = 10'b1000000011;
        b_tbl[1] = 10'b0100000111;
        b_tbl[2] = 10'b0011110100;
        b_tbl[3] = 10'b0000001111;
        b_tbl[4] = 10'b0000000011;

        reset = 1'b0; fifo_empty = 1'b1; out_ready = 1'b0;
        b_fifo_empty = 1'b1; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {22'd0, vec_a()}, {22'd0, 10'b0000000011});
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_empty", {22'd0, vec_a()}, {22'd0, 10'b0000000011});

        // Single sample: FIFO non-empty for one cycle, accepted on first out_valid
        for (int unsigned i = 0; i < 9; i++) begin
            step(i != 0, i == 7);
            chk($sformatf("single_c%0d", i), {22'd0, vec_a()}, {22'd0, single_tbl[i]});
        end

        // Back-to-back with FIFO never empty and out_ready high
        for (int unsigned k = 0; k < 22; k++) begin
            step(1'b0, 1'b1);
            chk($sformatf("b2b_rd_k%0d", k), {31'd0, fifo_rd_en}, {31'd0, k % 7 == 0});
            chk($sformatf("b2b_ov_k%0d", k), {31'd0, out_valid}, {31'd0, k != 0 && k % 7 == 0});
            chk($sformatf("b2b_busy_k%0d", k), {31'd0, busy}, {31'd0, k != 0});
        end

        // Backpressure: OUT reached at b=6, out_ready withheld until b=11
        for (int unsigned b = 0; b < 13; b++) begin
            step(1'b0, b == 11);
            chk($sformatf("bp_ov_b%0d", b), {31'd0, out_valid}, {31'd0, b >= 6 && b <= 11});
            chk($sformatf("bp_rd_b%0d", b), {31'd0, fifo_rd_en}, {31'd0, b == 11});
            chk($sformatf("bp_sh_b%0d", b), {31'd0, shift_en}, {31'd0, b == 0 || b == 12});
        end
`ifdef FIR_SCHED_STALL_CNT_EN
        chk("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
`endif

        // Reset in the middle of COMP
        step(1'b0, 1'b0);
        chk("rst_pre_g0", {22'd0, vec_a()}, {22'd0, 10'b0011100100});
        step(1'b0, 1'b0);
        chk("rst_pre_g1", {30'd0, group}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_comp", {22'd0, vec_a()}, {22'd0, 10'b0000000011});
`ifdef FIR_SCHED_STALL_CNT_EN
        chk("stall_cnt_rst", {16'd0, stall_cnt}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("restart_rd", {22'd0, vec_a()}, {22'd0, 10'b1000000011});
        step(1'b1, 1'b0);
        chk("restart_load", {22'd0, vec_a()}, {22'd0, 10'b0100000111});
        step(1'b1, 1'b0);
        chk("restart_g0_clr", {22'd0, vec_a()}, {22'd0, 10'b0011100100});

        // Single-group, zero-latency instance
        for (int unsigned c = 0; c < 5; c++) begin
            step_b(c != 0, c == 3);
            chk($sformatf("g1_lat0_c%0d", c), {22'd0, vec_b()}, {22'd0, b_tbl[c]});
        end

`ifdef FIR_SCHED_STALL_CNT_EN
        // Instance A reached OUT with out_ready low; let the counter saturate
        repeat (70000) @(negedge clk);
        #1;
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        chk("stall_sat_ov", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        #1;
        chk("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
